// File: rtl/add_pipe_valid.sv
// add_pipe_valid: parametrised adder pipeline with per-stage valid bits,
// ready/valid backpressure and bubble collapse. Optional unsigned saturation.
module add_pipe_valid #(
    parameter int WIDTH    = 32,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_carry
);

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic [STAGES-1:0] en;

    // Returns {flag, data}: carry-out, or clamp indication when saturating.
    function automatic logic [WIDTH:0] add_fn(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if ((SATURATE != 0) && s[WIDTH]) begin
            s = {1'b1, {WIDTH{1'b1}}};
        end
        return s;
    endfunction

    // Stage i may load when it, or any stage downstream of it, is empty, or
    // the consumer takes the result; flattened form of the enable chain.
    always_comb begin
        logic acc;
        en = '0;
        for (int i = 0; i < STAGES; i++) begin
            acc = out_ready;
            for (int j = i; j < STAGES; j++) begin
                acc = acc | ~v_q[j];
            end
            en[i] = acc;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v_q[STAGES-1];

    // Valid bits advance with their enables.
    always_comb begin
        v_d = v_q;
        if (en[0]) begin
            v_d[0] = in_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (en[i]) begin
                v_d[i] = v_q[i-1];
            end
        end
    end

    // Valid register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            v_q <= v_d;
        end
    end

    generate
        if (STAGES == 1) begin : g_one
            logic [WIDTH-1:0] data_q;
            logic [WIDTH-1:0] data_d;
            logic             carry_q;
            logic             carry_d;

            // Single stage: the add goes straight from x/y into s0.
            always_comb begin
                logic [WIDTH:0] sum;
                sum     = add_fn(x, y);
                data_d  = data_q;
                carry_d = carry_q;
                if (en[0]) begin
                    data_d  = sum[WIDTH-1:0];
                    carry_d = sum[WIDTH];
                end
            end

            // Result register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    data_q  <= '0;
                    carry_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    carry_q <= carry_d;
                end
            end

            assign out       = data_q;
            assign out_carry = carry_q;
        end else begin : g_multi
            logic [WIDTH-1:0]  x0_q;
            logic [WIDTH-1:0]  x0_d;
            logic [WIDTH-1:0]  y0_q;
            logic [WIDTH-1:0]  y0_d;
            logic [WIDTH-1:0]  data_q [1:STAGES-1];
            logic [WIDTH-1:0]  data_d [1:STAGES-1];
            logic [STAGES-1:1] carry_q;
            logic [STAGES-1:1] carry_d;

            // s0 captures raw operands, s1 holds the sum, deeper stages delay it.
            always_comb begin
                logic [WIDTH:0] sum;
                sum     = add_fn(x0_q, y0_q);
                x0_d    = en[0] ? x : x0_q;
                y0_d    = en[0] ? y : y0_q;
                data_d  = data_q;
                carry_d = carry_q;
                if (en[1]) begin
                    data_d[1]  = sum[WIDTH-1:0];
                    carry_d[1] = sum[WIDTH];
                end
                for (int i = 2; i < STAGES; i++) begin
                    if (en[i]) begin
                        data_d[i]  = data_q[i-1];
                        carry_d[i] = carry_q[i-1];
                    end
                end
            end

            // Payload registers for all stages.
            always_ff @(posedge clk) begin
                if (rst) begin
                    x0_q    <= '0;
                    y0_q    <= '0;
                    data_q  <= '{default: '0};
                    carry_q <= '0;
                end else begin
                    x0_q    <= x0_d;
                    y0_q    <= y0_d;
                    data_q  <= data_d;
                    carry_q <= carry_d;
                end
            end

            assign out       = data_q[STAGES-1];
            assign out_carry = carry_q[STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_add_pipe_valid.sv
// tb_add_pipe_valid: four configurations driven with shared stimulus, each
// checked against an item-level queue model of the pipeline.
module tb_add_pipe_valid;

    localparam int NI = 4;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] xs;
    logic [31:0] ys;

    logic [NI-1:0] ir;
    logic [NI-1:0] ov;
    logic [NI-1:0] oc;
    logic [31:0]   o0;
    logic [7:0]    o1;
    logic [7:0]    o2;
    logic [7:0]    o3;

    int st  [NI] = '{2, 3, 3, 1};
    int wd  [NI] = '{32, 8, 8, 8};
    int sat [NI] = '{0, 0, 1, 1};

    int          cnt [NI];
    int          pos [NI][8];
    logic [32:0] res [NI][8];

    int n_checks = 0;
    int n_errors = 0;

    add_pipe_valid #(.WIDTH(32), .STAGES(2), .SATURATE(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
        .x(xs), .y(ys), .out_valid(ov[0]), .out_ready(out_ready),
        .out(o0), .out_carry(oc[0]));
    add_pipe_valid #(.WIDTH(8), .STAGES(3), .SATURATE(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov[1]), .out_ready(out_ready),
        .out(o1), .out_carry(oc[1]));
    add_pipe_valid #(.WIDTH(8), .STAGES(3), .SATURATE(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov[2]), .out_ready(out_ready),
        .out(o2), .out_carry(oc[2]));
    add_pipe_valid #(.WIDTH(8), .STAGES(1), .SATURATE(1)) u_d (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]),
        .x(xs[7:0]), .y(ys[7:0]), .out_valid(ov[3]), .out_ready(out_ready),
        .out(o3), .out_carry(oc[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] get_out(input int k);
        case (k)
            0:       return o0;
            1:       return {24'd0, o1};
            2:       return {24'd0, o2};
            default: return {24'd0, o3};
        endcase
    endfunction

    // Expected {flag, data} from the arithmetic rules.
    function automatic logic [32:0] exp_res(input int k, input logic [31:0] xx, input logic [31:0] yy);
        longint unsigned m, a, b, t, d;
        logic c;
        m = (64'd1 << wd[k]) - 64'd1;
        a = {32'd0, xx} & m;
        b = {32'd0, yy} & m;
        t = a + b;
        c = (t >> wd[k]) != 0;
        d = (c && sat[k] != 0) ? m : (t & m);
        return {c, d[31:0]};
    endfunction

    // Advance one clock edge: oldest item leaves if ready, others move up
    // one slot when the slot ahead is free, new item enters slot 0.
    task automatic model_edge(input int k, input logic iv, input logic [31:0] xx,
                              input logic [31:0] yy, input logic ordy, input logic r);
        int          np [8];
        logic [32:0] nr [8];
        int n, lim, p, s;
        if (r) begin
            cnt[k] = 0;
            return;
        end
        s   = st[k];
        lim = s - 1;
        n   = 0;
        for (int j = 0; j < cnt[k]; j++) begin
            p = pos[k][j];
            if (p == s - 1 && ordy) continue;
            if (p < s - 1) p = (p + 1 <= lim) ? p + 1 : lim;
            np[n] = p;
            nr[n] = res[k][j];
            n++;
            lim = p - 1;
        end
        if (iv && (cnt[k] < s || ordy)) begin
            np[n] = 0;
            nr[n] = exp_res(k, xx, yy);
            n++;
        end
        for (int j = 0; j < n; j++) begin
            pos[k][j] = np[j];
            res[k][j] = nr[j];
        end
        cnt[k] = n;
    endtask

    task automatic check_outputs();
        logic ev;
        for (int k = 0; k < NI; k++) begin
            ev = (cnt[k] > 0) && (pos[k][0] == st[k] - 1);
            check($sformatf("out_valid[%0d]", k), {63'd0, ov[k]}, {63'd0, ev});
            if (ev) begin
                check($sformatf("out[%0d]", k), {32'd0, get_out(k)}, {32'd0, res[k][0][31:0]});
                check($sformatf("out_carry[%0d]", k), {63'd0, oc[k]}, {63'd0, res[k][0][32]});
            end
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("rst_out[%0d]", k), {32'd0, get_out(k)}, 64'd0);
            check($sformatf("rst_carry[%0d]", k), {63'd0, oc[k]}, 64'd0);
            check($sformatf("rst_in_ready[%0d]", k), {63'd0, ir[k]}, 64'd1);
        end
    endtask

    // One cycle: apply inputs after negedge, check in_ready, clock, check outputs.
    task automatic step(input logic iv, input logic [31:0] xx, input logic [31:0] yy,
                        input logic ordy, input logic r);
        in_valid  = iv;
        xs        = xx;
        ys        = yy;
        out_ready = ordy;
        rst       = r;
        #1;
        if (!r) begin
            for (int k = 0; k < NI; k++) begin
                check($sformatf("in_ready[%0d]", k), {63'd0, ir[k]},
                      {63'd0, (cnt[k] < st[k]) || ordy});
            end
        end
        @(posedge clk);
        for (int k = 0; k < NI; k++) model_edge(k, iv, xx, yy, ordy, r);
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        in_valid  = 1'b0;
        out_ready = 1'b0;
        xs        = '0;
        ys        = '0;
        rst       = 1'b1;
        for (int k = 0; k < NI; k++) cnt[k] = 0;
        @(negedge clk);

        step(1'b0, 0, 0, 1'b0, 1'b1);
        step(1'b0, 0, 0, 1'b0, 1'b1);
        rst = 1'b0;
        #1;
        check_reset();

        // Single transaction and boundary sums.
        step(1'b1, 32'd3, 32'd5, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 0, 1'b1, 1'b0);
        step(1'b1, 32'hF0, 32'h20, 1'b1, 1'b0);
        step(1'b1, 32'h7F, 32'h01, 1'b1, 1'b0);
        step(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
        step(1'b1, 32'hFF, 32'hFF, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Back-to-back stream.
        for (int i = 0; i < 10; i++) step(1'b1, i, i, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Full backpressure, then release.
        for (int i = 0; i < 6; i++) step(1'b1, 32'd100 + i, 32'd7 * i, 1'b0, 1'b0);
        repeat (8) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Bubble collapse behind a stalled output.
        step(1'b1, 32'd11, 32'd22, 1'b0, 1'b0);
        repeat (2) step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 32'd33, 32'd44, 1'b0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 1'b0);
        step(1'b1, 32'd55, 32'd66, 1'b0, 1'b0);
        step(1'b1, 32'd77, 32'd88, 1'b0, 1'b0);
        repeat (6) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        repeat (6) step(1'b0, 0, 0, 1'b1, 1'b0);

        // Reset with items in flight and a handshake in the reset cycle.
        step(1'b1, 32'd9, 32'd9, 1'b0, 1'b0);
        step(1'b1, 32'd8, 32'd8, 1'b0, 1'b0);
        step(1'b1, 32'd5, 32'd5, 1'b1, 1'b1);
        rst = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset();
        step(1'b1, 32'd1, 32'd1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 0, 0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/add_pipe_valid.md
Name: add_pipe_valid

Overview:
- Parametrised successor of the fixed two-stage 32-bit adder pipeline.
- Operand width and pipeline depth are configurable; adds an unsigned saturating mode and a carry/saturation flag.
- Per-stage valid bits with ready/valid backpressure; bubbles collapse, so an empty stage accepts new data even while downstream stages are stalled.
- Used as the leaf arithmetic stage wrapped by generated pipeline top modules.

Parameters:
- WIDTH, 32, operand and result width in bits (>=1).
- STAGES, 2, number of register stages from input acceptance to output (>=1).
- SATURATE, 0, 0 = wrap-around add; 1 = unsigned saturating add (result clamps to all-ones).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  x/y hold a valid operand pair.
- in_ready  output  1  block accepts x/y this cycle.
- x  input  WIDTH  operand A, unsigned.
- y  input  WIDTH  operand B, unsigned.
- out_valid  output  1  out/out_carry hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- out  output  WIDTH  sum result.
- out_carry  output  1  SATURATE=0: carry-out of the add. SATURATE=1: 1 when the result was clamped.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset: while rst=1 at a clk edge, all stage valid bits and all data/flag registers clear to 0. After reset, out_valid=0, out=0, out_carry=0 and in_ready=1.
- Reset mid-operation: in-flight results are discarded and not emitted. A handshake in the same cycle as rst=1 is ignored.
- Stages are s0..s(STAGES-1). Each holds valid v[i], a data payload and a carry flag; s(STAGES-1) drives the outputs.
- Enables:
  - en[STAGES-1] = !v[STAGES-1] | out_ready
  - en[i] = !v[i] | en[i+1]
  - in_ready = en[0]
- Combinational path out_ready -> in_ready through the enable chain is permitted and intended.
- When en[i]=1, stage i loads from its predecessor: v[i] <= v[i-1] (v[0] <= in_valid), and data loads with it. When en[i]=0, stage i holds.
- Arithmetic: full sum is the (WIDTH+1)-bit value x+y.
  - SATURATE=0: data = sum[WIDTH-1:0], carry = sum[WIDTH].
  - SATURATE=1: if sum[WIDTH]=1 then data = all-ones and carry=1; else data = sum[WIDTH-1:0] and carry=0.
- Placement of the add:
  - STAGES=1: add is computed from x/y into s0.
  - STAGES>=2: s0 registers the raw x/y; the add is computed from s0 into s1; s2..s(STAGES-1) delay the sum.
- Latency: a pair accepted at edge T (in_valid & in_ready) gives out_valid=1 after edge T+STAGES-1, i.e. STAGES cycles later with no stall.
- Throughput: 1 result per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, out and out_carry are held stable.
- Bubble collapse: upstream stages keep filling empty slots until every stage is valid; only then does in_ready go 0.
- Capacity: STAGES results; no loss or duplication.
- Ordering: results emerge in acceptance order.
- Payload when in_valid=0 is don't-care, but v tracks correctly.
- Simultaneous events: a full pipe with out_ready=1 accepts a new input in the same cycle it emits a result (in_ready=1).

Test Plan:
- WIDTH=32, STAGES=2: x=3, y=5, in_valid=1 for one cycle, out_ready=1 -> out_valid=1 exactly 2 cycles later with out=8, out_carry=0; out_valid=0 the next cycle.
- WIDTH=8, SATURATE=0: x=0xF0, y=0x20 -> out=0x10, out_carry=1. Repeat with SATURATE=1 -> out=0xFF, out_carry=1. Also x=0x7F, y=0x01 with SATURATE=1 -> out=0x80, out_carry=0.
- STAGES=3: stream x=i, y=i for i=0..9 back-to-back, out_ready=1 -> outputs 0,2,...,18 on consecutive cycles starting 3 cycles after the first accept; in_ready stays 1 throughout.
- Backpressure, STAGES=3: hold out_ready=0 while streaming -> exactly 3 accepted, then in_ready=0 and out holds the first sum stable. Release out_ready -> all results emitted in order with no loss or duplicates.
- Bubble collapse, STAGES=3: one item at the output stalled (out_ready=0), then send a second item 2 cycles later -> second item is accepted and advances to s1. in_ready stays 1 until 3 items are held.
- Reset mid-stream: with 2 items in flight, assert rst for 1 cycle -> next cycle out_valid=0, out=0, in_ready=1. The flushed items never appear, and a new pair (1,1) yields out=2 after STAGES cycles.
